// File: rtl/l2_arbiter.sv
// Round-robin arbiter that shares the single L2 slave port between the L1 I-cache and D-cache.
// The winner's command is registered onto the L2 port; ack is routed back combinationally.
module l2_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_stb,
  input  logic         i_cyc,
  input  logic         i_we,
  input  logic [11:0]  i_adr,
  input  logic [127:0] i_dat_m,
  input  logic [15:0]  i_sel,
  output logic         i_ack,
  output logic [127:0] i_dat_s,
  input  logic         d_stb,
  input  logic         d_cyc,
  input  logic         d_we,
  input  logic [11:0]  d_adr,
  input  logic [127:0] d_dat_m,
  input  logic [15:0]  d_sel,
  output logic         d_ack,
  output logic [127:0] d_dat_s,
  output logic         m_stb,
  output logic         m_cyc,
  output logic         m_we,
  output logic [11:0]  m_adr,
  output logic [127:0] m_dat_m,
  output logic [15:0]  m_sel,
  input  logic         m_ack,
  input  logic [127:0] m_dat_s
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   i_pend, d_pend;
  logic   take_i, take_d, done;
  logic   active;

  assign i_pend = i_stb & i_cyc;
  assign d_pend = d_stb & d_cyc;

  // last_grant = 1 means D was served last, so I wins a tie.
  always_comb begin
    state_next = state;
    take_i     = 1'b0;
    take_d     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && (!d_pend || last_grant)) begin
          take_i     = 1'b1;
          state_next = GRANT_I;
        end else if (d_pend) begin
          take_d     = 1'b1;
          state_next = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (m_ack) begin
          done       = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      last_grant <= 1'b1;
      m_we       <= 1'b0;
      m_adr      <= 12'h000;
      m_dat_m    <= 128'h0;
      m_sel      <= 16'h0000;
    end else if (take_i) begin
      active     <= 1'b1;
      last_grant <= 1'b0;
      m_we       <= i_we;
      m_adr      <= i_adr;
      m_dat_m    <= i_dat_m;
      m_sel      <= i_sel;
    end else if (take_d) begin
      active     <= 1'b1;
      last_grant <= 1'b1;
      m_we       <= d_we;
      m_adr      <= d_adr;
      m_dat_m    <= d_dat_m;
      m_sel      <= d_sel;
    end else if (done) begin
      active     <= 1'b0;
    end
  end

  assign m_stb = active;
  assign m_cyc = active;

  // Acks are gated by the grant state, so spurious L2 acks in IDLE/RELEASE go nowhere.
  assign i_ack   = (state == GRANT_I) & m_ack;
  assign d_ack   = (state == GRANT_D) & m_ack;
  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single L2 cache slave port between the L1 instruction cache and the L1 data cache. Each L1 miss/writeback arrives as a wishbone-style line request (12-bit line address, 128-bit line). The arbiter grants one requester at a time with round-robin fairness and registers the winner's command onto the L2 port. It returns the L2 acknowledge and read data only to the granted requester. It sits between the two L1 cache controllers and the L2 cache in the memory hierarchy.

## Interface
- No parameters; line width 128, line address 12, byte select 16 are fixed.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_stb, i_cyc, i_we  in  1 each  I-side request strobe/cycle/write-enable
- i_adr  in  12  I-side line address
- i_dat_m  in  128  I-side write line
- i_sel  in  16  I-side byte select
- i_ack  out  1  I-side acknowledge
- i_dat_s  out  128  I-side read line
- d_stb, d_cyc, d_we, d_adr, d_dat_m, d_sel  in  same widths as I-side  D-side request
- d_ack  out  1  D-side acknowledge
- d_dat_s  out  128  D-side read line
- m_stb, m_cyc, m_we  out  1 each  to L2
- m_adr  out  12  to L2
- m_dat_m  out  128  to L2
- m_sel  out  16  to L2
- m_ack  in  1  L2 acknowledge
- m_dat_s  in  128  L2 read line

## Operation
- A requester is pending when its stb && cyc is high.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE, no pending requester: stay in IDLE.
- IDLE, exactly one pending: go to that requester's GRANT state.
- IDLE, both pending: grant the side not served last, tracked by last_grant (0=I, 1=D).
- On the grant edge:
  - Capture the winner's adr, dat_m, sel, we into m_adr/m_dat_m/m_sel/m_we registers.
  - Set m_stb = m_cyc = 1.
  - Update last_grant.
- GRANT_x: hold the captured command unchanged. Requester inputs are ignored after capture. Wait for m_ack.
- GRANT_x with m_ack = 1:
  - Combinationally assert x_ack and drive x_dat_s = m_dat_s in the same cycle.
  - Clear m_stb/m_cyc on the next edge and go to RELEASE.
- RELEASE: one cycle with no grant, so the requester can drop stb after its ack. Then return to IDLE.
- The non-granted ack is always 0. Both dat_s outputs are driven from m_dat_s at all times; only the ack is gated.
- m_ack while in IDLE or RELEASE (spurious): ignored, no ack forwarded, no state change.
- A requester dropping stb mid-grant does not abort the L2 transaction. The transaction completes and the ack is still pulsed.
- m_we is forwarded as captured. An I-side write is legal and passed through.

## Timing
- Reset values: state IDLE, last_grant = 1 (I wins the first tie), m_stb/m_cyc/m_we = 0, m_adr/m_dat_m/m_sel = 0, i_ack = d_ack = 0.
- Async reset mid-transaction: m_stb/m_cyc drop immediately, no ack is forwarded, state returns to IDLE.
- Request to L2 strobe: a request pending in IDLE at edge N gives m_cyc = 1 after edge N (1 cycle).
- L2 ack to requester ack: 0 cycles (combinational pass-through).
- m_stb/m_cyc fall at the edge after m_ack.
- Minimum back-to-back spacing: grant, ack, RELEASE, IDLE, re-grant. With a 1-cycle L2 the arbiter issues one transaction every 4 cycles.
- A request arriving during GRANT or RELEASE waits; it is evaluated in the next IDLE cycle.
- Round-robin bound: with both sides continuously pending, grants strictly alternate. No requester waits more than one other transaction.

## Test plan
- Reset with both sides requesting: hold rst_n = 0 for 3 cycles with i_stb/i_cyc and d_stb/d_cyc high → all outputs 0. After release, the first grant is I (m_adr = i_adr = 12'h0A5); d_ack stays 0.
- Single D write: d_we = 1, d_adr = 12'h3F0, d_dat_m = 128'hDEAD…BEEF, d_sel = 16'hFFFF; L2 acks 3 cycles later → m_we = 1 and m_adr = 12'h3F0 held stable for all 3 cycles, d_ack high exactly 1 cycle coincident with m_ack, i_ack = 0 throughout.
- Continuous contention: both sides hold requests for 6 transactions, 1-cycle L2 → grant order I, D, I, D, I, D. Each transaction 4 cycles apart.
- Read data routing: I read at 12'h010 with L2 returning m_dat_s = 128'h1234 → i_dat_s = 128'h1234 and i_ack = 1 in the same cycle; d_ack = 0.
- Mid-transaction reset: assert rst_n low 1 cycle after grant, before m_ack → m_cyc falls asynchronously. A later m_ack pulse produces no i_ack/d_ack. A fresh request is then granted normally.
- Spurious ack / dropped strobe: pulse m_ack in IDLE → no ack, state unchanged. Then D drops d_stb mid-grant → the transaction completes and d_ack still pulses on m_ack.
